// File: rtl/pwmdir_pkg.sv
// Shared types and helpers for the multi-channel PWM/DIR generator.
// Dead-time insertion is enabled by defining PWMDIR_DEADTIME_EN.
package pwmdir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } ch_state_e;

  // Counter width able to hold 0..period.
  function automatic int cnt_w(input int period);
    return $clog2(period + 1);
  endfunction

  // |v| without overflow for the most-negative value, clamped to lim.
  function automatic logic [63:0] abs_sat(
    input logic signed [63:0] v,
    input logic [63:0]        lim
  );
    logic [63:0] a;
    a = v[63] ? 64'(-v) : 64'(v);
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/pwmdir_channel.sv
// One PWM/DIR channel: boundary-loaded shadows, state machine, compare.
// PWMDIR_DEADTIME_EN adds a DEAD state after a direction reversal.
module pwmdir_channel
  import pwmdir_pkg::*;
#(
  parameter int CMD_W    = 32,
  parameter int PERIOD   = 1000,
  parameter int DEADTIME = 50,
  parameter int CNT_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [CMD_W-1:0] cmd,
  input  logic [CNT_W-1:0]        cnt,
  input  logic                    boundary,
  output logic                    pwm,
  output logic                    dir,
  output logic signed [CMD_W-1:0] duty_fb
);

  localparam logic [63:0] LIM = 64'(PERIOD);

  ch_state_e               state_q, state_d;
  logic [CNT_W-1:0]        duty_sh_q, duty_sh_d;
  logic                    dir_q, dir_d;
  logic                    pwm_q, pwm_d;
  logic signed [CMD_W-1:0] fb_q, fb_d;

  logic [CNT_W-1:0]        mag;
  logic                    new_dir;
  logic signed [CMD_W-1:0] mag_s;
  logic signed [CMD_W-1:0] fb_new;

  assign mag     = CNT_W'(abs_sat(64'(cmd), LIM));
  assign new_dir = (cmd > 0);
  assign mag_s   = CMD_W'(mag);
  assign fb_new  = new_dir ? mag_s : -mag_s;

`ifdef PWMDIR_DEADTIME_EN
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  logic [DW-1:0] dead_q, dead_d;
`else
  logic unused_dt;
  assign unused_dt = ^32'(DEADTIME);
`endif

  // Next state: disable is immediate, loads happen only at the wrap.
  always_comb begin
    state_d   = state_q;
    duty_sh_d = duty_sh_q;
    dir_d     = dir_q;
    fb_d      = fb_q;
    pwm_d     = 1'b0;
`ifdef PWMDIR_DEADTIME_EN
    dead_d    = dead_q;
`endif
    if (!enable) begin
      state_d   = ST_IDLE;
      duty_sh_d = '0;
      fb_d      = '0;
`ifdef PWMDIR_DEADTIME_EN
      dead_d    = '0;
`endif
    end else begin
      if (state_q == ST_RUN)
        pwm_d = (cnt < duty_sh_q);
`ifdef PWMDIR_DEADTIME_EN
      if (state_q == ST_DEAD) begin
        dead_d = dead_q - 1'b1;
        if (dead_q == DW'(1))
          state_d = ST_RUN;
      end
`endif
      if (boundary) begin
        duty_sh_d = mag;
        dir_d     = new_dir;
        fb_d      = fb_new;
        if (state_q == ST_IDLE)
          state_d = ST_RUN;
`ifdef PWMDIR_DEADTIME_EN
        // Reversal under load: bridge stays off while dir settles.
        if (state_q != ST_IDLE && new_dir != dir_q &&
            mag != '0 && DEADTIME > 0) begin
          state_d = ST_DEAD;
          dead_d  = DW'(DEADTIME);
          pwm_d   = 1'b0;
        end
`endif
      end
    end
  end

  // Channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      duty_sh_q <= '0;
      dir_q     <= 1'b0;
      pwm_q     <= 1'b0;
      fb_q      <= '0;
`ifdef PWMDIR_DEADTIME_EN
      dead_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      duty_sh_q <= duty_sh_d;
      dir_q     <= dir_d;
      pwm_q     <= pwm_d;
      fb_q      <= fb_d;
`ifdef PWMDIR_DEADTIME_EN
      dead_q    <= dead_d;
`endif
    end
  end

  assign pwm     = pwm_q;
  assign dir     = dir_q;
  assign duty_fb = fb_q;

endmodule

// File: rtl/pwmdir_multi.sv
// Multi-channel PWM/DIR generator with a shared period counter.
// Define PWMDIR_DEADTIME_EN to insert dead time on DIR reversal.
module pwmdir_multi
  import pwmdir_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CMD_W    = 32,
  parameter int PERIOD   = 1000,
  parameter int DEADTIME = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*CMD_W-1:0] duty_cmd,
  output logic [CHANNELS-1:0]       pwm,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS*CMD_W-1:0] duty_fb,
  output logic                      period_tick
);

  localparam int CNT_W = cnt_w(PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             boundary;

  assign boundary = (cnt_q == CNT_W'(PERIOD - 1));

  // Free-running period counter; tick marks cnt==0 after a wrap.
  always_comb begin
    cnt_d  = boundary ? '0 : cnt_q + 1'b1;
    tick_d = boundary;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign period_tick = tick_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwmdir_channel #(
      .CMD_W    (CMD_W),
      .PERIOD   (PERIOD),
      .DEADTIME (DEADTIME),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable[i]),
      .cmd      (duty_cmd[i*CMD_W +: CMD_W]),
      .cnt      (cnt_q),
      .boundary (boundary),
      .pwm      (pwm[i]),
      .dir      (dir[i]),
      .duty_fb  (duty_fb[i*CMD_W +: CMD_W])
    );
  end

endmodule

// File: tb/tb_pwmdir_multi.sv
// Randomized bench for pwmdir_multi against a behavioural model.
// Model honours PWMDIR_DEADTIME_EN when defined.
module tb_pwmdir_multi;

  localparam int CH = 4;
  localparam int W  = 32;
  localparam int P  = 10;
  localparam int DT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   enable;
  logic [CH*W-1:0] duty_cmd;
  logic [CH-1:0]   pwm;
  logic [CH-1:0]   dir;
  logic [CH*W-1:0] duty_fb;
  logic            period_tick;

  pwmdir_multi #(
    .CHANNELS (CH),
    .CMD_W    (W),
    .PERIOD   (P),
    .DEADTIME (DT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .duty_cmd    (duty_cmd),
    .pwm         (pwm),
    .dir         (dir),
    .duty_fb     (duty_fb),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(
    input string             tag,
    input logic signed [63:0] got,
    input logic signed [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Behavioural model: applied duty per period, plus dead-time budget.
  int     m_cnt;
  bit     m_tick;
  bit     m_act  [CH];
  int     m_mag  [CH];
  bit     m_dir  [CH];
  longint m_fb   [CH];
  int     m_dead [CH];
  bit     m_pwm  [CH];

  task automatic model_reset();
    m_cnt  = 0;
    m_tick = 0;
    for (int i = 0; i < CH; i++) begin
      m_act[i]  = 0;
      m_mag[i]  = 0;
      m_dir[i]  = 0;
      m_fb[i]   = 0;
      m_dead[i] = 0;
      m_pwm[i]  = 0;
    end
  endtask

  task automatic model_step();
    bit     wrap;
    longint c;
    longint nm;
    bit     nd;
    bit     p;
    bit     enter;
    wrap = (m_cnt == P - 1);
    for (int i = 0; i < CH; i++) begin
      c  = longint'($signed(duty_cmd[i*W +: W]));
      nm = (c < 0) ? -c : c;
      if (nm > P) nm = P;
      nd = (c > 0);
      p  = m_act[i] && m_dead[i] == 0 && enable[i] && m_cnt < m_mag[i];
      if (!enable[i]) begin
        m_act[i]  = 0;
        m_mag[i]  = 0;
        m_fb[i]   = 0;
        m_dead[i] = 0;
      end else begin
        enter = 0;
`ifdef PWMDIR_DEADTIME_EN
        if (wrap && m_act[i] && nd != m_dir[i] && nm != 0 && DT > 0)
          enter = 1;
`endif
        if (enter) begin
          m_dead[i] = DT;
          p = 0;
        end else if (m_dead[i] > 0) begin
          m_dead[i]--;
        end
        if (wrap) begin
          m_mag[i] = int'(nm);
          m_dir[i] = nd;
          m_fb[i]  = nd ? nm : -nm;
          m_act[i] = 1;
        end
      end
      m_pwm[i] = p;
    end
    m_tick = wrap;
    m_cnt  = wrap ? 0 : m_cnt + 1;
  endtask

  task automatic check_all();
    check("tick", period_tick, m_tick);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("pwm%0d@%0d", i, m_cnt), pwm[i], m_pwm[i]);
      check($sformatf("dir%0d", i), dir[i], m_dir[i]);
      check($sformatf("fb%0d", i),
            $signed(duty_fb[i*W +: W]), m_fb[i]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_cmd(input int i, input logic [W-1:0] v);
    duty_cmd[i*W +: W] = v;
  endtask

  function automatic logic [W-1:0] pick_cmd();
    logic [W-1:0] v;
    v = '0;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'h7fff_ffff;
      2: v = '0;
      3: v = W'($urandom_range(0, P));
      4: v = -W'($urandom_range(0, P));
      5: v = W'($urandom);
      6: v = W'($urandom_range(P + 1, 4 * P));
      default: v = -W'($urandom_range(1, P - 1));
    endcase
    return v;
  endfunction

  int hi;

  initial begin
    rst      = 1'b1;
    enable   = '0;
    duty_cmd = '0;
    model_reset();
    #12;
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Single channel +3, most-negative on channel 1.
    enable = 4'b0011;
    set_cmd(0, 32'd3);
    set_cmd(1, 32'h8000_0000);
    step(25);
    hi = 0;
    for (int k = 0; k < P; k++) begin
      step(1);
      hi += int'(pwm[0]);
    end
    check("t1_high", hi, 3);
    check("t1_dir", dir[0], 1);
    hi = 0;
    for (int k = 0; k < P; k++) begin
      step(1);
      hi += int'(pwm[1]);
    end
    check("t2_high", hi, P);
    check("t2_fb", $signed(duty_fb[W +: W]), -P);

    // Mid-period command change.
    for (int k = 0; k < P && m_cnt != 5; k++) step(1);
    check("t3_sync", m_cnt, 5);
    set_cmd(0, 32'd7);
    step(2 * P + 3);

    // Disable at cnt==1 with duty 8, then re-enable.
    set_cmd(0, 32'd8);
    step(P);
    for (int k = 0; k < P && m_cnt != 1; k++) step(1);
    enable[0] = 1'b0;
    step(3);
    enable[0] = 1'b1;
    step(2 * P);

    // Reversal under load.
    set_cmd(0, -W'(7));
    step(3 * P);

    // Asynchronous reset while channel 1 drives high.
    check("t6_pre", pwm[1], 1);
    rst = 1'b1;
    #1;
    check("t6_pwm", pwm, 0);
    check("t6_dir", dir, 0);
    check("t6_tick", period_tick, 0);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    step(P + 2);

    // Random traffic.
    enable = 4'b1111;
    for (int i = 0; i < CH; i++) set_cmd(i, pick_cmd());
    for (int k = 0; k < 1500; k++) begin
      step(1);
      if ($urandom_range(0, 7) == 0)
        set_cmd(int'($urandom_range(0, CH - 1)), pick_cmd());
      if ($urandom_range(0, 39) == 0)
        enable[$urandom_range(0, CH - 1)] ^= 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
